// File: rtl/i2c_cmd_arbiter_pkg.sv
// package_i2c
// Shared types for the I2C command path.
//   t_i2c_cmd       : command word handed from a requester to the I2C master
//   t_i2c_arb_state : arbiter state (IDLE -> ISSUE -> WAIT -> IDLE)
//   next_index      : modulo-increment of a requester index
package package_i2c;

  typedef struct packed {
    logic [6:0] dev_addr;
    logic       rd;
    logic [7:0] reg_addr;
  } t_i2c_cmd;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } t_i2c_arb_state;

  // Next requester after idx, wrapping at num requesters.
  function automatic logic [1:0] next_index(input logic [1:0] idx, input int num);
    return (int'(idx) == num - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/i2c_cmd_arbiter_picker.sv
// rr_priority_picker
// Combinational round-robin search: starting at ptr and moving upward
// modulo p_num_req, the first asserted request wins.
//   req   : request vector
//   ptr   : requester with highest priority this cycle
//   grant : one-hot winner (all zero when nobody requests)
//   index : binary index of the winner
//   any   : at least one request is present
module rr_priority_picker
  import package_i2c::*;
#(
  parameter int p_num_req = 2
) (
  input  logic [p_num_req-1:0] req,
  input  logic [1:0]           ptr,
  output logic [p_num_req-1:0] grant,
  output logic [1:0]           index,
  output logic                 any
);

  logic found;

  // Outer loop walks priority order (ptr, ptr+1, ...), inner loop maps that
  // position onto a constant bit index so no variable bit-select is needed.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int k = 0; k < p_num_req; k++) begin
      for (int i = 0; i < p_num_req; i++) begin
        if (!found && req[i] && (i == (int'(ptr) + k) % p_num_req)) begin
          grant[i] = 1'b1;
          index    = 2'(i);
          found    = 1'b1;
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter
// Shares one I2C master between p_num_req requesters with round-robin
// fairness. A granted command is latched and presented to the master; the
// arbiter then waits for the master to finish (or time out) and reports
// completion to the requester that owned the transaction.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_req_valid/cmd/wr_data : per-requester command requests
//   o_req_ready        : accept strobe to the granted requester
//   o_req_done/err     : completion / timeout strobes to the owner
//   o_rd_valid/o_rd_data : read bytes routed to the owner
//   o_cmd_valid/o_cmd_data/o_wr_data, i_cmd_ready : master command handshake
//   i_rd_valid/i_rd_data : read bytes from the master
module i2c_cmd_arbiter
  import package_i2c::*;
#(
  parameter int p_num_req = 2,
  parameter int p_timeout = 2**20 - 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [p_num_req-1:0]         i_req_valid,
  input  t_i2c_cmd [p_num_req-1:0]     i_req_cmd,
  input  logic [p_num_req-1:0][7:0]    i_req_wr_data,
  output logic [p_num_req-1:0]         o_req_ready,
  output logic [p_num_req-1:0]         o_req_done,
  output logic [p_num_req-1:0]         o_req_err,
  output logic [p_num_req-1:0]         o_rd_valid,
  output logic [7:0]                   o_rd_data,
  output logic                         o_cmd_valid,
  output t_i2c_cmd                     o_cmd_data,
  output logic [7:0]                   o_wr_data,
  input  logic                         i_cmd_ready,
  input  logic                         i_rd_valid,
  input  logic [7:0]                   i_rd_data
);

  // The timer holds the number of WAIT cycles already elapsed, so the
  // p_timeout-th WAIT cycle is the one where it equals p_timeout-1.
  localparam int c_timer_w = (p_timeout < 2) ? 1 : $clog2(p_timeout);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(p_timeout - 1);

  typedef struct packed {
    t_i2c_arb_state         state;
    logic [1:0]             ptr;
    logic [1:0]             owner;
    logic [c_timer_w-1:0]   timer;
    logic                   guard;
    t_i2c_cmd               cmd;
    logic [7:0]             wr_data;
  } t_arb_regs;

  // ARB_IDLE is encoded as zero, so all-zero is the reset image.
  localparam t_arb_regs c_reset = '0;

  t_arb_regs cur, nxt;

  logic [p_num_req-1:0] grant;
  logic [1:0]           grant_index;
  logic                 any_req;
  logic [p_num_req-1:0] owner_hot;
  t_i2c_cmd             sel_cmd;
  logic [7:0]           sel_wr;
  logic [p_num_req-1:0] ready_raw, done_raw, err_raw, rdv_raw;
  logic                 cmd_valid_raw;

  rr_priority_picker #(.p_num_req(p_num_req)) u_picker (
    .req   (i_req_valid),
    .ptr   (cur.ptr),
    .grant (grant),
    .index (grant_index),
    .any   (any_req)
  );

  // One-hot form of the current owner, used to steer done/err/read strobes.
  always_comb begin
    owner_hot = '0;
    for (int i = 0; i < p_num_req; i++) begin
      owner_hot[i] = (cur.owner == 2'(i));
    end
  end

  // Select the winner's command and write byte from the one-hot grant.
  always_comb begin
    sel_cmd = '0;
    sel_wr  = '0;
    for (int i = 0; i < p_num_req; i++) begin
      if (grant[i]) begin
        sel_cmd = i_req_cmd[i];
        sel_wr  = i_req_wr_data[i];
      end
    end
  end

  // Next-state and strobe logic. In WAIT a ready from the master beats a
  // simultaneous timeout; the guard masks the master's ready during the
  // first WAIT cycle because it only drops ready one cycle after accepting.
  always_comb begin
    nxt           = cur;
    ready_raw     = '0;
    done_raw      = '0;
    err_raw       = '0;
    rdv_raw       = '0;
    cmd_valid_raw = 1'b0;
    case (cur.state)
      ARB_IDLE: begin
        if (i_cmd_ready && any_req) begin
          ready_raw   = grant;
          nxt.state   = ARB_ISSUE;
          nxt.owner   = grant_index;
          nxt.cmd     = sel_cmd;
          nxt.wr_data = sel_wr;
        end
      end
      ARB_ISSUE: begin
        cmd_valid_raw = 1'b1;
        if (i_cmd_ready) begin
          nxt.state = ARB_WAIT;
          nxt.timer = '0;
          nxt.guard = 1'b1;
        end
      end
      ARB_WAIT: begin
        rdv_raw   = owner_hot & {p_num_req{i_rd_valid}};
        nxt.guard = 1'b0;
        nxt.timer = cur.timer + c_timer_w'(1);
        if (!cur.guard && i_cmd_ready) begin
          done_raw  = owner_hot;
          nxt.ptr   = next_index(cur.owner, p_num_req);
          nxt.state = ARB_IDLE;
        end else if (cur.timer == c_timer_last) begin
          done_raw  = owner_hot;
          err_raw   = owner_hot;
          nxt.ptr   = next_index(cur.owner, p_num_req);
          nxt.state = ARB_IDLE;
        end
      end
      default: begin
        nxt = c_reset;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur <= c_reset;
    end else begin
      cur <= nxt;
    end
  end

  // Strobes are masked while reset is asserted so an abandoned transaction
  // never reports done or err.
  assign o_req_ready = ready_raw & {p_num_req{~i_rst}};
  assign o_req_done  = done_raw  & {p_num_req{~i_rst}};
  assign o_req_err   = err_raw   & {p_num_req{~i_rst}};
  assign o_rd_valid  = rdv_raw   & {p_num_req{~i_rst}};
  assign o_cmd_valid = cmd_valid_raw & ~i_rst;
  assign o_cmd_data  = cur.cmd;
  assign o_wr_data   = cur.wr_data;
  assign o_rd_data   = i_rd_data;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// tb_i2c_cmd_arbiter
// Directed scenarios followed by a randomized run, all checked cycle by cycle
// against a transaction-level reference model of the arbiter.
module tb_i2c_cmd_arbiter;
  import package_i2c::*;

  localparam int N       = 3;
  localparam int TIMEOUT = 16;
  localparam int PH_IDLE = 0, PH_ISSUE = 1, PH_WAIT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         req_valid;
  t_i2c_cmd [N-1:0]     req_cmd;
  logic [N-1:0][7:0]    req_wr;
  logic [N-1:0]         req_ready, req_done, req_err, rd_valid_out;
  logic [7:0]           rd_data_out;
  logic                 cmd_valid;
  t_i2c_cmd             cmd_data;
  logic [7:0]           wr_data;
  logic                 cmd_ready;
  logic                 rd_valid_in;
  logic [7:0]           rd_data_in;

  int checks = 0;
  int errors = 0;

  // reference model state
  int       m_phase, m_ptr, m_owner, m_waited;
  bit       m_first;
  t_i2c_cmd m_cmd;
  logic [7:0] m_wr;

  // outputs observed in the most recent applied cycle
  logic [N-1:0] obs_ready, obs_done, obs_err, obs_rdv;
  logic         obs_cv;
  t_i2c_cmd     obs_cmd;
  logic [7:0]   obs_wr;

  i2c_cmd_arbiter #(.p_num_req(N), .p_timeout(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .i_req_cmd     (req_cmd),
    .i_req_wr_data (req_wr),
    .o_req_ready   (req_ready),
    .o_req_done    (req_done),
    .o_req_err     (req_err),
    .o_rd_valid    (rd_valid_out),
    .o_rd_data     (rd_data_out),
    .o_cmd_valid   (cmd_valid),
    .o_cmd_data    (cmd_data),
    .o_wr_data     (wr_data),
    .i_cmd_ready   (cmd_ready),
    .i_rd_valid    (rd_valid_in),
    .i_rd_data     (rd_data_in)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] x);
    for (int i = 0; i < N; i++) begin
      if (x == (N'(1) << i)) return i;
    end
    return -1;
  endfunction

  // Drives one cycle of inputs, checks all outputs against the model,
  // advances the model, then steps to just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic cr,
                               input logic rv, input logic [7:0] rd);
    logic [N-1:0] e_ready, e_done, e_err, e_rdv;
    logic         e_cv;
    int           g;
    rst = r; req_valid = v; cmd_ready = cr; rd_valid_in = rv; rd_data_in = rd;
    #1;
    obs_ready = req_ready; obs_done = req_done; obs_err = req_err;
    obs_rdv = rd_valid_out; obs_cv = cmd_valid; obs_cmd = cmd_data; obs_wr = wr_data;
    e_ready = '0; e_done = '0; e_err = '0; e_rdv = '0; e_cv = 1'b0; g = -1;
    if (!r) begin
      if (m_phase == PH_IDLE) begin
        if (cr && v != '0) begin
          g = rr_winner(v, m_ptr);
          e_ready[g] = 1'b1;
        end
      end else if (m_phase == PH_ISSUE) begin
        e_cv = 1'b1;
      end else begin
        if (rv) e_rdv[m_owner] = 1'b1;
        if (!m_first && cr) begin
          e_done[m_owner] = 1'b1;
        end else if (m_waited + 1 == TIMEOUT) begin
          e_done[m_owner] = 1'b1;
          e_err[m_owner]  = 1'b1;
        end
      end
    end
    checkOutput("req_ready", 32'(obs_ready), 32'(e_ready));
    checkOutput("req_done",  32'(obs_done),  32'(e_done));
    checkOutput("req_err",   32'(obs_err),   32'(e_err));
    checkOutput("rd_valid",  32'(obs_rdv),   32'(e_rdv));
    checkOutput("cmd_valid", 32'(obs_cv),    32'(e_cv));
    checkOutput("cmd_data",  32'(obs_cmd),   32'(m_cmd));
    checkOutput("wr_data",   32'(obs_wr),    32'(m_wr));
    checkOutput("rd_data",   32'(rd_data_out), 32'(rd));
    if (r) begin
      m_phase = PH_IDLE; m_ptr = 0; m_owner = 0; m_waited = 0; m_first = 0;
      m_cmd = '0; m_wr = '0;
    end else if (m_phase == PH_IDLE) begin
      if (g >= 0) begin
        m_owner = g; m_cmd = req_cmd[g]; m_wr = req_wr[g]; m_phase = PH_ISSUE;
      end
    end else if (m_phase == PH_ISSUE) begin
      if (cr) begin
        m_phase = PH_WAIT; m_waited = 0; m_first = 1;
      end
    end else begin
      if (e_done != '0) begin
        m_ptr = (m_owner + 1) % N;
        m_phase = PH_IDLE;
      end else begin
        m_waited++;
        m_first = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[$];
    int done_at;
    int cnt0, cnt1;
    logic [N-1:0] err_seen;
    t_i2c_cmd c1;

    rst = 1'b1; req_valid = '0; req_cmd = '0; req_wr = '0;
    cmd_ready = 1'b0; rd_valid_in = 1'b0; rd_data_in = '0;
    m_phase = PH_IDLE; m_ptr = 0; m_owner = 0; m_waited = 0; m_first = 0;
    m_cmd = '0; m_wr = '0;
    @(posedge clk);
    #1;
    $display("[TB] reset");
    applyStimulus(1, '0, 0, 0, 8'h00);
    applyStimulus(1, '0, 1, 1, 8'h11);

    $display("[TB] single request");
    c1 = '{dev_addr: 7'h50, rd: 1'b0, reg_addr: 8'h12};
    req_cmd[0] = c1; req_wr[0] = 8'h80;
    applyStimulus(0, 3'b001, 1, 0, 8'h00);
    checkOutput("t1_grant", 32'(obs_ready), 32'h1);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    checkOutput("t1_cmd_valid", 32'(obs_cv), 32'h1);
    checkOutput("t1_cmd", 32'(obs_cmd), 32'(c1));
    checkOutput("t1_wr", 32'(obs_wr), 32'h80);
    for (int k = 0; k < 3; k++) applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    checkOutput("t1_done", 32'(obs_done), 32'h1);
    checkOutput("t1_no_err", 32'(obs_err), 32'h0);

    $display("[TB] contention");
    applyStimulus(1, '0, 0, 0, 8'h00);
    req_cmd[1] = '{dev_addr: 7'h21, rd: 1'b1, reg_addr: 8'h40}; req_wr[1] = 8'h34;
    for (int t = 0; t < 4; t++) begin
      applyStimulus(0, 3'b011, 1, 0, 8'h00);
      order.push_back(onehot_idx(obs_ready));
      applyStimulus(0, 3'b011, 1, 0, 8'h00);
      applyStimulus(0, 3'b011, 1, 0, 8'h00);
      checkOutput("t2_guard", 32'(obs_done), 32'h0);
      applyStimulus(0, 3'b011, 0, 0, 8'h00);
      applyStimulus(0, 3'b011, 1, 0, 8'h00);
      checkOutput("t2_done", 32'(obs_done), 32'(N'(1) << (t % 2)));
    end
    for (int t = 0; t < 4; t++) checkOutput("t2_order", 32'(order[t]), 32'(t % 2));

    $display("[TB] timeout");
    applyStimulus(1, '0, 0, 0, 8'h00);
    applyStimulus(0, 3'b001, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    done_at = 0; err_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(0, 3'b000, 0, 0, 8'h00);
      if (obs_done != '0) begin
        done_at = k; err_seen = obs_err;
        break;
      end
    end
    checkOutput("t3_done_cycle", 32'(done_at), 32'(TIMEOUT));
    checkOutput("t3_err", 32'(err_seen), 32'h1);
    applyStimulus(0, 3'b001, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    for (int k = 1; k < TIMEOUT; k++) applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    checkOutput("t3_ready_wins_done", 32'(obs_done), 32'h1);
    checkOutput("t3_ready_wins_err", 32'(obs_err), 32'h0);

    $display("[TB] read routing");
    applyStimulus(1, '0, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 1, 8'h55);
    checkOutput("t4_idle_drop", 32'(obs_rdv), 32'h0);
    applyStimulus(0, 3'b010, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    cnt0 = 0; cnt1 = 0;
    applyStimulus(0, 3'b000, 0, 1, 8'hA1); cnt0 += int'(obs_rdv[0]); cnt1 += int'(obs_rdv[1]);
    applyStimulus(0, 3'b000, 0, 0, 8'h00); cnt0 += int'(obs_rdv[0]); cnt1 += int'(obs_rdv[1]);
    applyStimulus(0, 3'b000, 0, 1, 8'hA2); cnt0 += int'(obs_rdv[0]); cnt1 += int'(obs_rdv[1]);
    applyStimulus(0, 3'b000, 0, 1, 8'hA3); cnt0 += int'(obs_rdv[0]); cnt1 += int'(obs_rdv[1]);
    applyStimulus(0, 3'b000, 1, 0, 8'h00); cnt0 += int'(obs_rdv[0]); cnt1 += int'(obs_rdv[1]);
    checkOutput("t4_done", 32'(obs_done), 32'h2);
    checkOutput("t4_rd_owner", 32'(cnt1), 32'd3);
    checkOutput("t4_rd_other", 32'(cnt0), 32'd0);

    $display("[TB] reset mid-wait");
    applyStimulus(0, 3'b010, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(1, 3'b000, 1, 1, 8'h77);
    checkOutput("t5_no_done", 32'(obs_done), 32'h0);
    checkOutput("t5_no_rdv", 32'(obs_rdv), 32'h0);
    applyStimulus(0, 3'b011, 1, 0, 8'h00);
    checkOutput("t5_ptr0", 32'(obs_ready), 32'h1);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);

    $display("[TB] master busy");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 3'b001, 0, 0, 8'h00);
      checkOutput("t6_busy", 32'(obs_ready), 32'h0);
    end
    applyStimulus(0, 3'b001, 1, 0, 8'h00);
    checkOutput("t6_grant", 32'(obs_ready), 32'h1);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);

    $display("[TB] withdrawn request");
    applyStimulus(0, 3'b010, 0, 0, 8'h00);
    applyStimulus(0, 3'b001, 1, 0, 8'h00);
    checkOutput("t7_withdrawn", 32'(obs_ready), 32'h1);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);
    applyStimulus(0, 3'b000, 0, 0, 8'h00);
    applyStimulus(0, 3'b000, 1, 0, 8'h00);

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < N; i++) begin
        req_cmd[i] = t_i2c_cmd'(16'($urandom));
        req_wr[i]  = 8'($urandom);
      end
      applyStimulus(($urandom_range(0, 63) == 0), N'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
